dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Data-memory access controller between the EX/MEM pipeline register and a variable-latency data memory with a req/ack handshake. Detects loads and stores leaving EX/MEM and generates byte-lane-steered requests. Stalls the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) until the memory acknowledges, and injects bubbles into MEM/WB while stalled. Also extends load data per funct3 and flags misaligned/illegal accesses and memory timeouts.

## Interface
- DATA_WIDTH, 32, data bus width (only 32 supported)
- ADDR_WIDTH, 32, address width
- TIMEOUT_CYCLES, 255, max cycles in REQ before abort (1..255)

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  load in EX/MEM
- mem_write  in  1  store in EX/MEM
- mem_daddr  in  ADDR_WIDTH  byte address
- mem_write_data  in  DATA_WIDTH  store data (low-aligned)
- mem_funct3  in  3  access size/sign
- dmem_req  out  1  request valid
- dmem_we  out  1  write enable
- dmem_addr  out  ADDR_WIDTH  word address (bits [1:0] = 0)
- dmem_wdata  out  DATA_WIDTH  lane-steered store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  memory completion, single-cycle pulse
- dmem_rdata  in  DATA_WIDTH  read word, valid with ack
- load_data  out  DATA_WIDTH  extended load result
- load_valid  out  1  load_data valid for MEM/WB capture
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- mem_wb_flush  out  1  write bubble into MEM/WB
- fault  out  1  one-cycle pulse: misaligned or illegal funct3
- timeout  out  1  one-cycle pulse: ack not received in time

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - access = mem_read | mem_write; write wins if both are set.
  - Legal, aligned access: latch we/addr/wdata/be/funct3/offset into request regs. Assert stall and mem_wb_flush combinationally. Next state REQ.
  - Illegal access: pulse fault, assert mem_wb_flush, keep stall=0, issue no request, stay in IDLE.
    - Illegal funct3: 011, 110, 111, or 100/101 on a store.
    - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- REQ:
  - dmem_req=1, stall=1, mem_wb_flush=1; request regs stay stable.
  - On dmem_ack: register the extended rdata into load_data (loads only) and go to DONE.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT_CYCLES: pulse timeout, set load_data=0, go to DONE.
- DONE:
  - stall=0, mem_wb_flush=0.
  - load_valid=1 for exactly one cycle if the access was a load.
  - Next state IDLE unconditionally. The held instruction leaves EX/MEM at this edge and does not re-trigger.
- Store steering:
  - SB (000): be=0001<<off; wdata = byte replicated ×4.
  - SH (001): be=0011<<{off[1],0}; wdata = halfword replicated ×2.
  - SW (010): be=1111.
- Loads: be=1111, we=0. Extract the byte/half at the latched offset. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- dmem_ack outside REQ is ignored.

## Timing
- Reset (async): state IDLE, counter 0, request regs 0, all outputs 0 (load_data 0).
- Zero-wait memory (ack in first REQ cycle): stall high for 2 cycles (IDLE-detect, REQ), load_valid in the 3rd cycle.
- General case: stall cycles = 2 + number of REQ cycles without ack.
- Timeout: REQ lasts TIMEOUT_CYCLES+1 cycles max.
- Back-to-back accesses: the next access is detected in the cycle after DONE.
- Reset mid-REQ: dmem_req drops immediately (async). A later ack is ignored.

## Structure
- Package dmem_ctrl_pkg holds:
  - state enum (IDLE, REQ, DONE)
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - legality/alignment function
- Sub-module lsu_lane_align: purely combinational. Store be/wdata steering plus load extract/extend. Instantiated once per direction, or once with a mode input.
- FSM, counter and request regs stay in the top module.

## Test plan
- SW addr 0x104, data 0xDEADBEEF, ack after 0 waits → dmem_be=1111, dmem_addr=0x104, stall 2 cycles, no fault.
- LB addr 0x103, rdata 0x80FF_FF7F, ack after 3 waits → load_data=0xFFFF_FF80, stall 5 cycles, load_valid 1 cycle.
- SH addr 0x202, data 0x0000_1234 → be=1100, wdata=0x1234_1234. Then LHU at 0x202, rdata 0xABCD_0000 → load_data=0x0000_ABCD.
- LW addr 0x101 → fault pulse, no dmem_req, stall=0, mem_wb_flush=1 that cycle.
- Load with ack never asserted, TIMEOUT_CYCLES=4 → timeout pulse after 4 REQ cycles, load_data=0, pipeline resumes.
- rst asserted in the second REQ cycle → outputs 0 immediately. A subsequent ack is ignored, and the next access starts cleanly from IDLE.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types, funct3 encodings and access legality check for the data-memory controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when funct3 is a legal size for the direction and the offset is naturally aligned.
    function automatic logic access_ok(input logic [2:0] funct3, input logic [1:0] offset,
                                       input logic is_store);
        logic ok;
        case (funct3)
            F3_B:           ok = 1'b1;
            F3_H:           ok = ~offset[0];
            F3_W:           ok = (offset == 2'b00);
            F3_BU:          ok = ~is_store;
            F3_HU:          ok = ~is_store & ~offset[0];
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane.sv
// Byte-lane steering for stores and byte/half extraction with sign/zero extension for loads.
module lsu_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3)
            F3_B: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                be    = 4'b0011 << {offset[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: issues lane-steered req/ack transactions for EX/MEM loads and
// stores, stalls the pipeline while waiting, and reports faults and timeouts.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_daddr,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [2:0]            mem_funct3,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  stall,
    output logic                  mem_wb_flush,
    output logic                  fault,
    output logic                  timeout
);

    state_t                state, state_next;
    logic [7:0]            wait_cnt;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [3:0]            req_be;
    logic [2:0]            req_funct3;
    logic [1:0]            req_off;

    logic                  access, legal, timed_out;
    logic [2:0]            lane_funct3;
    logic [1:0]            lane_off;
    logic [3:0]            lane_be;
    logic [31:0]           lane_wdata, lane_load;

    // Reset gates detection so a held instruction cannot raise stall/flush while rst is high.
    assign access    = (mem_read | mem_write) & ~rst;
    assign legal     = access_ok(mem_funct3, mem_daddr[1:0], mem_write);
    assign timed_out = (wait_cnt == 8'(TIMEOUT_CYCLES));

    // One aligner serves both directions: live inputs while detecting, latched regs afterwards.
    assign lane_funct3 = (state == IDLE) ? mem_funct3     : req_funct3;
    assign lane_off    = (state == IDLE) ? mem_daddr[1:0] : req_off;

    lsu_lane_align u_lane (
        .funct3     (lane_funct3),
        .offset     (lane_off),
        .store_data (mem_write_data),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    assign dmem_we    = req_we;
    assign dmem_addr  = req_addr;
    assign dmem_wdata = req_wdata;
    assign dmem_be    = req_be;

    always_comb begin
        state_next   = state;
        dmem_req     = 1'b0;
        stall        = 1'b0;
        mem_wb_flush = 1'b0;
        fault        = 1'b0;
        timeout      = 1'b0;
        load_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    mem_wb_flush = 1'b1;
                    if (legal) begin
                        stall      = 1'b1;
                        state_next = REQ;
                    end else begin
                        fault = 1'b1;
                    end
                end
            end
            REQ: begin
                dmem_req     = 1'b1;
                stall        = 1'b1;
                mem_wb_flush = 1'b1;
                if (dmem_ack) begin
                    state_next = DONE;
                end else if (timed_out) begin
                    timeout    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                load_valid = ~req_we;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_be     <= '0;
            req_funct3 <= '0;
            req_off    <= '0;
            load_data  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (access && legal) begin
                        req_we     <= mem_write;
                        req_addr   <= {mem_daddr[ADDR_WIDTH-1:2], 2'b00};
                        req_wdata  <= lane_wdata;
                        req_be     <= mem_write ? lane_be : 4'b1111;
                        req_funct3 <= mem_funct3;
                        req_off    <= mem_daddr[1:0];
                        wait_cnt   <= '0;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        if (!req_we) load_data <= lane_load;
                    end else if (timed_out) begin
                        load_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: the driver queues expected responses, a negedge monitor
// pops and compares them as requests, stall windows, loads, faults and timeouts appear.
module tb_dmem_access_ctrl;
    import dmem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_daddr, mem_write_data;
    logic [2:0]  mem_funct3;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
    logic [3:0]  dmem_be;
    logic        load_valid, stall, mem_wb_flush, fault, timeout;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_daddr      (mem_daddr),
        .mem_write_data (mem_write_data),
        .mem_funct3     (mem_funct3),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .stall          (stall),
        .mem_wb_flush   (mem_wb_flush),
        .fault          (fault),
        .timeout        (timeout)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk_wd;
    } req_t;

    req_t        req_q[$];
    logic [31:0] ld_q[$];
    int          stall_q[$];
    int          fault_q[$];
    int          to_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    logic prev_req = 1'b0, prev_lv = 1'b0;
    int   scnt = 0, rcnt = 0;

    always @(negedge clk) begin
        req_t r;
        int   e;
        if (dmem_req) rcnt = prev_req ? rcnt + 1 : 1;
        if (dmem_req && !prev_req) begin
            if (req_q.size() == 0) chk("req_unexpected", 1, 0);
            else begin
                r = req_q.pop_front();
                chk("req_we", {31'd0, dmem_we}, {31'd0, r.we});
                chk("req_addr", dmem_addr, r.addr);
                chk("req_be", {28'd0, dmem_be}, {28'd0, r.be});
                if (r.chk_wd) chk("req_wdata", dmem_wdata, r.wdata);
            end
        end
        if (stall) scnt++;
        else if (scnt != 0) begin
            if (stall_q.size() == 0) chk("stall_unexpected", 1, 0);
            else begin
                e = stall_q.pop_front();
                chk("stall_cycles", scnt, e);
            end
            scnt = 0;
        end
        if (fault) begin
            if (fault_q.size() == 0) chk("fault_unexpected", 1, 0);
            else begin
                void'(fault_q.pop_front());
                chk("fault_stall_req_flush", {29'd0, stall, dmem_req, mem_wb_flush}, 32'b001);
            end
        end
        if (timeout) begin
            if (to_q.size() == 0) chk("timeout_unexpected", 1, 0);
            else begin
                e = to_q.pop_front();
                chk("timeout_req_cycles", rcnt, e);
            end
        end
        if (load_valid) begin
            chk("load_valid_width", {31'd0, prev_lv}, 0);
            if (ld_q.size() == 0) chk("load_unexpected", 1, 0);
            else chk("load_data", load_data, ld_q.pop_front());
        end
        prev_req = dmem_req;
        prev_lv  = load_valid;
    end

    // Driver
    task automatic expect_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, input logic chk_wd, input int stall_n);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wd; r.be = be; r.chk_wd = chk_wd;
        req_q.push_back(r);
        stall_q.push_back(stall_n);
    endtask

    task automatic present(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] f3);
        mem_read       = ~wr;
        mem_write      = wr;
        mem_daddr      = addr;
        mem_write_data = wd;
        mem_funct3     = f3;
    endtask

    task automatic release_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input int waits, input logic [31:0] rdata,
                          input logic give_ack);
        int guard;
        present(wr, addr, wd, f3);
        @(posedge clk); #1;
        chk("req_entered", {31'd0, dmem_req}, 1);
        if (give_ack) begin
            repeat (waits) begin @(posedge clk); #1; end
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
            @(posedge clk); #1;
            dmem_ack   = 1'b0;
        end else begin
            guard = 0;
            while (dmem_req && guard < 50) begin @(posedge clk); #1; guard++; end
            chk("req_left_bound", {31'd0, dmem_req}, 0);
        end
        @(posedge clk); #1;
        release_inputs();
    endtask

    task automatic illegal(input logic wr, input logic [31:0] addr, input logic [2:0] f3);
        fault_q.push_back(1);
        present(wr, addr, 32'h0, f3);
        @(posedge clk); #1;
        chk("illegal_no_req", {31'd0, dmem_req}, 0);
        release_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        release_inputs();
        mem_daddr = '0; mem_write_data = '0; mem_funct3 = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, dmem_req}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_flush", {31'd0, mem_wb_flush}, 0);
        chk("rst_load_valid", {31'd0, load_valid}, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_be", {28'd0, dmem_be}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        expect_req(1'b1, 32'h104, 32'hDEADBEEF, 4'b1111, 1'b1, 2);
        access(1'b1, 32'h104, 32'hDEADBEEF, F3_W, 0, 32'h0, 1'b1);

        expect_req(1'b0, 32'h100, 32'h0, 4'b1111, 1'b0, 5);
        ld_q.push_back(32'hFFFF_FF80);
        access(1'b0, 32'h103, 32'h0, F3_B, 3, 32'h80FF_FF7F, 1'b1);

        expect_req(1'b1, 32'h200, 32'h1234_1234, 4'b1100, 1'b1, 3);
        access(1'b1, 32'h202, 32'h0000_1234, F3_H, 1, 32'h0, 1'b1);

        expect_req(1'b0, 32'h200, 32'h0, 4'b1111, 1'b0, 2);
        ld_q.push_back(32'h0000_ABCD);
        access(1'b0, 32'h202, 32'h0, F3_HU, 0, 32'hABCD_0000, 1'b1);

        expect_req(1'b1, 32'h104, 32'h5A5A_5A5A, 4'b0100, 1'b1, 4);
        access(1'b1, 32'h106, 32'h0000_005A, F3_B, 2, 32'h0, 1'b1);

        expect_req(1'b0, 32'h000, 32'h0, 4'b1111, 1'b0, 2);
        ld_q.push_back(32'hFFFF_8001);
        access(1'b0, 32'h002, 32'h0, F3_H, 0, 32'h8001_0000, 1'b1);

        illegal(1'b0, 32'h101, F3_W);
        illegal(1'b1, 32'h108, F3_BU);

        // Timeout: ack never arrives, REQ lasts TIMEOUT_CYCLES+1 = 5 cycles
        expect_req(1'b0, 32'h300, 32'h0, 4'b1111, 1'b0, 6);
        to_q.push_back(5);
        ld_q.push_back(32'h0);
        access(1'b0, 32'h300, 32'h0, F3_W, 0, 32'h0, 1'b0);

        // Reset in the second REQ cycle
        expect_req(1'b0, 32'h400, 32'h0, 4'b1111, 1'b0, 2);
        present(1'b0, 32'h400, 32'h0, F3_W);
        @(posedge clk); #1;
        chk("rstmid_req_entered", {31'd0, dmem_req}, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstmid_req", {31'd0, dmem_req}, 0);
        chk("rstmid_stall", {31'd0, stall}, 0);
        chk("rstmid_flush", {31'd0, mem_wb_flush}, 0);
        release_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("stray_ack_no_req", {31'd0, dmem_req}, 0);
        chk("stray_ack_load_data", load_data, 0);
        @(posedge clk); #1;

        expect_req(1'b0, 32'h500, 32'h0, 4'b1111, 1'b0, 2);
        ld_q.push_back(32'h0000_00AB);
        access(1'b0, 32'h501, 32'h0, F3_BU, 0, 32'h0000_AB00, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        chk("req_q_drained", req_q.size(), 0);
        chk("ld_q_drained", ld_q.size(), 0);
        chk("stall_q_drained", stall_q.size(), 0);
        chk("fault_q_drained", fault_q.size(), 0);
        chk("to_q_drained", to_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
